// File: rtl/alu_ctrl_if.sv
// rtl/alu_ctrl_if.sv - request/response handshake bundle between a requester and alu_ctrl
interface alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_z;
    logic             rsp_n;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_z, rsp_n, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_z, rsp_n, rsp_err
    );
endinterface

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - multi-cycle sequencer driving an external ALU, adding ABS/MIN/MAX as two passes
module alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_ctrl_if.slave        bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_add,
    output logic             alu_neg,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             busy
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NEG  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_ABS  = 3'b100;
    localparam logic [2:0] OP_MIN  = 3'b101;
    localparam logic [2:0] OP_MAX  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    // {add, neg, sub} as the ALU expects them
    localparam logic [2:0] CTL_ADD  = 3'b000;
    localparam logic [2:0] CTL_SUB  = 3'b101;
    localparam logic [2:0] CTL_NEG  = 3'b110;
    localparam logic [2:0] CTL_PASS = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;

    state_t           state, next_state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, res_r;
    logic             z_r, n_r, err_r, cmp_n;
    logic [2:0]       ctrl;
    logic             two_step;

    assign two_step = (op_r == OP_ABS) || (op_r == OP_MIN) || (op_r == OP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (bus.req_valid) next_state = (bus.req_op == OP_ILL) ? DONE : EXEC1;
            EXEC1: next_state = two_step ? EXEC2 : DONE;
            EXEC2: next_state = DONE;
            DONE:  if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ALU drive depends only on registered state so the ALU path starts at flops
    always_comb begin
        ctrl  = CTL_ADD;
        alu_a = '0;
        alu_b = '0;
        case (state)
            EXEC1: begin
                alu_a = a_r;
                alu_b = b_r;
                case (op_r)
                    OP_SUB, OP_MIN, OP_MAX: ctrl = CTL_SUB;
                    OP_NEG:                 ctrl = CTL_NEG;
                    OP_PASS, OP_ABS:        ctrl = CTL_PASS;
                    default:                ctrl = CTL_ADD;
                endcase
            end
            EXEC2: begin
                case (op_r)
                    OP_ABS: begin
                        ctrl  = n_r ? CTL_NEG : CTL_PASS;
                        alu_a = a_r;
                    end
                    OP_MIN: begin
                        ctrl  = CTL_PASS;
                        alu_a = cmp_n ? a_r : b_r;
                    end
                    OP_MAX: begin
                        ctrl  = CTL_PASS;
                        alu_a = cmp_n ? b_r : a_r;
                    end
                    default: ctrl = CTL_ADD;
                endcase
            end
            default: ctrl = CTL_ADD;
        endcase
    end

    assign {alu_add, alu_neg, alu_sub} = ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            z_r   <= 1'b0;
            n_r   <= 1'b0;
            err_r <= 1'b0;
            cmp_n <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_r <= bus.req_op;
                    a_r  <= bus.req_a;
                    b_r  <= bus.req_b;
                    if (bus.req_op == OP_ILL) begin
                        res_r <= '0;
                        z_r   <= 1'b0;
                        n_r   <= 1'b0;
                        err_r <= 1'b1;
                    end else begin
                        err_r <= 1'b0;
                    end
                end
                EXEC1: begin
                    res_r <= alu_out;
                    z_r   <= alu_z;
                    n_r   <= alu_n;
                    if (op_r == OP_MIN || op_r == OP_MAX) cmp_n <= alu_n;
                end
                EXEC2: begin
                    res_r <= alu_out;
                    z_r   <= alu_z;
                    n_r   <= alu_n;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = res_r;
    assign bus.rsp_z     = z_r;
    assign bus.rsp_n     = n_r;
    assign bus.rsp_err   = err_r;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed self-checking bench for alu_ctrl with a behavioural ALU
module tb_alu_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_add, alu_neg, alu_sub, alu_z, alu_n, busy;

    alu_ctrl_if #(.WIDTH(W)) bus ();

    alu_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_add (alu_add),
        .alu_neg (alu_neg),
        .alu_sub (alu_sub),
        .alu_out (alu_out),
        .alu_z   (alu_z),
        .alu_n   (alu_n),
        .busy    (busy)
    );

    always_comb begin
        case ({alu_add, alu_neg, alu_sub})
            3'b000:  alu_out = alu_a + alu_b;
            3'b101:  alu_out = alu_a - alu_b;
            3'b110:  alu_out = -alu_a;
            3'b111:  alu_out = alu_a;
            default: alu_out = '0;
        endcase
    end
    assign alu_z = (alu_out == '0);
    assign alu_n = alu_out[W-1];

    int errors = 0;
    int checks = 0;

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_z, input logic exp_n, input logic exp_err,
                          input int exp_lat, input logic [2:0] exp_c1, input logic [2:0] exp_c2);
        logic got;
        int   lat;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b expected 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (k == 1 && !exp_err) begin
                checks++;
                if ({alu_add, alu_neg, alu_sub, busy} !== {exp_c1, 1'b1}) begin
                    errors++;
                    $display("FAIL %s step1 ctrl/busy: got %b%b%b/%b expected %b/1",
                             name, alu_add, alu_neg, alu_sub, busy, exp_c1);
                end
            end
            if (k == 2 && exp_lat == 3) begin
                checks++;
                if ({alu_add, alu_neg, alu_sub} !== exp_c2) begin
                    errors++;
                    $display("FAIL %s step2 ctrl: got %b%b%b expected %b", name, alu_add, alu_neg, alu_sub, exp_c2);
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = k;
                checks++;
                if ({bus.rsp_data, bus.rsp_z, bus.rsp_n, bus.rsp_err} !== {exp_d, exp_z, exp_n, exp_err}) begin
                    errors++;
                    $display("FAIL %s response: got data=%h z=%b n=%b err=%b expected data=%h z=%b n=%b err=%b",
                             name, bus.rsp_data, bus.rsp_z, bus.rsp_n, bus.rsp_err, exp_d, exp_z, exp_n, exp_err);
                end
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d (0 = no response)", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #12;
        checks++;
        if ({bus.req_ready, busy, bus.rsp_valid, bus.rsp_err, alu_add, alu_neg, alu_sub} !== 7'b1000000
            || bus.rsp_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b busy=%b vld=%b data=%h alu_a=%h", bus.req_ready, busy,
                     bus.rsp_valid, bus.rsp_data, alu_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_step();
        run_op("add_4_3",  3'b000, 32'd4, 32'd3, 32'd7,         1'b0, 1'b0, 1'b0, 2, 3'b000, 3'b000);
        run_op("sub_5_3",  3'b001, 32'd5, 32'd3, 32'd2,         1'b0, 1'b0, 1'b0, 2, 3'b101, 3'b000);
        run_op("neg_5",    3'b010, 32'd5, 32'd0, 32'hFFFFFFFB,  1'b0, 1'b1, 1'b0, 2, 3'b110, 3'b000);
        run_op("pass_5",   3'b011, 32'd5, 32'd9, 32'd5,         1'b0, 1'b0, 1'b0, 2, 3'b111, 3'b000);
        run_op("sub_5_5",  3'b001, 32'd5, 32'd5, 32'd0,         1'b1, 1'b0, 1'b0, 2, 3'b101, 3'b000);
        run_op("sub_2_3",  3'b001, 32'd2, 32'd3, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b0, 2, 3'b101, 3'b000);
    endtask

    task automatic test_abs();
        run_op("abs_m7",   3'b100, 32'hFFFFFFF9, 32'd0, 32'd7,        1'b0, 1'b0, 1'b0, 3, 3'b111, 3'b110);
        run_op("abs_0",    3'b100, 32'd0,        32'd0, 32'd0,        1'b1, 1'b0, 1'b0, 3, 3'b111, 3'b111);
        run_op("abs_min",  3'b100, 32'h80000000, 32'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 3, 3'b111, 3'b110);
    endtask

    task automatic test_min_max();
        run_op("min_3_9",  3'b101, 32'd3,        32'd9,        32'd3,        1'b0, 1'b0, 1'b0, 3, 3'b101, 3'b111);
        run_op("max_3_9",  3'b110, 32'd3,        32'd9,        32'd9,        1'b0, 1'b0, 1'b0, 3, 3'b101, 3'b111);
        run_op("min_m2_1", 3'b101, 32'hFFFFFFFE, 32'd1,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 3, 3'b101, 3'b111);
        run_op("max_5_5",  3'b110, 32'd5,        32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 3, 3'b101, 3'b111);
        run_op("min_ovf",  3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 3, 3'b101, 3'b111);
    endtask

    task automatic test_illegal_hold();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b111;
        bus.req_a     = 32'h1234;
        bus.req_b     = 32'h5678;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.rsp_err, bus.rsp_z, bus.rsp_n, bus.req_ready, alu_add, alu_neg, alu_sub} !== 8'b11000000
                || bus.rsp_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
                errors++;
                $display("FAIL illegal_hold cycle %0d: got vld=%b err=%b data=%h ready=%b ctrl=%b%b%b expected 1 1 0 0 000",
                         i + 1, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.req_ready, alu_add, alu_neg, alu_sub);
            end
        end
    endtask

    // Entered while the illegal response is still pending in DONE
    task automatic test_back_to_back();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'd10;
        bus.req_b     = 32'd20;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, busy, bus.rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_not_accepted: got ready=%b busy=%b vld=%b expected 1 0 0", bus.req_ready, busy, bus.rsp_valid);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_err} !== 2'b10 || bus.rsp_data !== 32'd30) begin
            errors++;
            $display("FAIL b2b_response: got vld=%b err=%b data=%h expected 1 0 0000001e",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b110;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd9;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, alu_add, alu_neg, alu_sub} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid_exec2: got busy=%b ctrl=%b%b%b expected 1 111", busy, alu_add, alu_neg, alu_sub);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, busy, bus.rsp_valid, bus.rsp_z, bus.rsp_n, bus.rsp_err, alu_add, alu_neg, alu_sub} !== 9'b100000000
            || bus.rsp_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got ready=%b busy=%b vld=%b data=%h alu_a=%h ctrl=%b%b%b",
                     bus.req_ready, busy, bus.rsp_valid, bus.rsp_data, alu_a, alu_add, alu_neg, alu_sub);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got a response after reset expected none");
        end
        run_op("add_after_rst", 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 2, 3'b000, 3'b000);
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_abs();
        test_min_max();
        test_illegal_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle sequencer that owns the 32-bit combinational ALU (ADD / SUB / NEGATE / PASS A, with Z and N flags) and executes single- and two-step operations for one requester.
- Accepts an opcode and two operands over a valid/ready request port.
- Drives the ALU operand and control lines, samples the ALU result and flags, and returns the result and flags over a valid/ready response port.
- Adds ABS, MIN and MAX by chaining two ALU passes. The ALU itself stays unchanged.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_op  in  3  opcode: 000 ADD, 001 SUB, 010 NEG, 011 PASS, 100 ABS, 101 MIN, 110 MAX, 111 illegal.
- req_a, req_b  in  WIDTH  operands; captured on request handshake.
- rsp_valid  out  1  response present; high only in DONE.
- rsp_ready  in  1  requester takes the response.
- rsp_data  out  WIDTH  result.
- rsp_z, rsp_n  out  1  zero / negative flags of the final ALU step.
- rsp_err  out  1  illegal opcode.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_add, alu_neg, alu_sub  out  1  ALU controls.
- alu_out  in  WIDTH  ALU result.
- alu_z, alu_n  in  1  ALU flags.
- busy  out  1  state != IDLE.

## Operation
- ALU control encodings (add, neg, sub):
  - ADD = 0,0,0
  - SUB = 1,0,1
  - NEG = 1,1,0
  - PASS = 1,1,1
- Idle/default drive: add/neg/sub = 0,0,0 and alu_a = alu_b = 0.
- States are IDLE, EXEC1, EXEC2, DONE.
  - IDLE: req_ready = 1. On req_valid, latch op/a/b into op_r/a_r/b_r.
    - Legal op: go to EXEC1.
    - Op 111: go to DONE with rsp_data = 0, rsp_z = 0, rsp_n = 0, rsp_err = 1. The ALU is not driven.
  - EXEC1: drive the step-1 operation and capture alu_out/alu_z/alu_n at the cycle end.
    - ADD/SUB/NEG/PASS/ABS: step 1 is that operation, with alu_a = a_r and alu_b = b_r. ABS step 1 is PASS with alu_a = a_r.
    - MIN/MAX: step 1 is SUB with alu_a = a_r and alu_b = b_r. Latch the alu_n result into cmp_n.
    - Single-step ops then go to DONE. ABS/MIN/MAX go to EXEC2.
  - EXEC2: drive step 2 and capture the result.
    - ABS: if the captured N = 1, NEG with alu_a = a_r; else PASS with alu_a = a_r.
    - MIN: PASS with alu_a = (cmp_n ? a_r : b_r).
    - MAX: PASS with alu_a = (cmp_n ? b_r : a_r).
    - alu_b = 0 in step 2. Next state is DONE.
  - DONE: rsp_valid = 1.
    - rsp_data/rsp_z/rsp_n/rsp_err hold the captured values and stay stable until the handshake.
    - On rsp_ready, go to IDLE. rsp_valid stays high until the handshake.
- Arithmetic wraps modulo 2^WIDTH and has no overflow detection.
  - ABS(0x80000000) = 0x80000000 with N = 1.
  - MIN/MAX compare uses raw N of A-B. Signed overflow in the compare is not corrected: MIN(0x7FFFFFFF, 0x80000000) returns 0x7FFFFFFF.
- rsp_err = 0 for all legal ops.

## Timing
- Request handshake in cycle 0 (req_valid & req_ready at the edge ending cycle 0).
- rsp_valid first high:
  - Cycle 2 for ADD/SUB/NEG/PASS.
  - Cycle 3 for ABS/MIN/MAX.
  - Cycle 1 for illegal.
- req_ready is low from cycle 1 until the cycle after the response handshake. The minimum request-to-request spacing is latency + 1.
- ALU outputs are registered-state driven: combinational from state/op_r/a_r/b_r/captured flags only, never from req_* or alu_*.
- The ALU path must close in one cycle. There is no multicycle path.
- Simultaneous rsp_ready and a new req_valid in DONE: only the response completes. The request is accepted in the following IDLE cycle.
- Reset, at any time including mid-operation: immediately go to IDLE.
  - req_ready = 1, busy = 0, rsp_valid = 0.
  - rsp_data = 0, rsp_z = 0, rsp_n = 0, rsp_err = 0.
  - alu_* = 0, op_r/a_r/b_r/cmp_n = 0.
  - The in-flight operation is discarded with no response.

## Test plan
- ADD 4+3, SUB 5-3, NEG 5, PASS 5: responses are 7, 2, 0xFFFFFFFB (N = 1), and 5, each with rsp_valid at cycle 2 and correct alu_add/neg/sub observed in cycle 1.
- SUB 5-5 -> 0 with Z = 1, N = 0. SUB 2-3 -> 0xFFFFFFFF with N = 1, Z = 0.
- ABS(-7) -> 7 with N = 0. ABS(0) -> 0 with Z = 1. ABS(0x80000000) -> 0x80000000 with N = 1. All at cycle 3.
- MIN(3,9) = 3, MAX(3,9) = 9, MIN(-2,1) = 0xFFFFFFFE, MAX(5,5) = 5, all at cycle 3.
- Op 111: rsp_err = 1 and rsp_data = 0 at cycle 1, with ALU controls idle throughout. Hold rsp_ready low for 5 cycles: the response stays stable and req_ready stays low.
- Assert rst_n low during EXEC2 of MAX: outputs return to reset values asynchronously, no response is produced, and a following ADD 1+1 returns 2 normally.
